// File: rtl/input_buffer_vc.sv
// -----------------------------------------------------------------------------
// input_buffer_vc
//
// Multi-virtual-channel input buffer for one router input port. NUM_VC
// independent circular FIFOs of DEPTH flits share a single storage array.
// VC v, slot s lives at index v*DEPTH+s. The read path is registered and
// qualified by a valid strobe. Refused requests raise one-cycle error pulses.
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-high, clears all control state
//   buf_write_i      write request for VC buf_wvc_i, flit on buf_data_i
//   buf_read_i       read request for VC buf_rvc_i
//   buf_data_o       registered read flit (holds when no read is accepted)
//   buf_valid_o      one-cycle strobe: buf_data_o holds a newly popped flit
//   buf_empty_o      per-VC empty flag, bit v = VC v
//   buf_full_o       per-VC full flag
//   buf_count_o      per-VC occupancy, VC v at [v*CNT_WIDTH +: CNT_WIDTH]
//   buf_overflow_o   one-cycle pulse: previous cycle's write was dropped
//   buf_underflow_o  one-cycle pulse: previous cycle's read was refused
// -----------------------------------------------------------------------------
module input_buffer_vc #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 5,
  parameter int NUM_VC     = 2,
  parameter int VC_BITS    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        buf_write_i,
  input  logic [VC_BITS-1:0]          buf_wvc_i,
  input  logic [DATA_WIDTH-1:0]       buf_data_i,
  input  logic                        buf_read_i,
  input  logic [VC_BITS-1:0]          buf_rvc_i,
  output logic [DATA_WIDTH-1:0]       buf_data_o,
  output logic                        buf_valid_o,
  output logic [NUM_VC-1:0]           buf_empty_o,
  output logic [NUM_VC-1:0]           buf_full_o,
  output logic [NUM_VC*CNT_WIDTH-1:0] buf_count_o,
  output logic                        buf_overflow_o,
  output logic                        buf_underflow_o
);

  localparam int ENTRIES = NUM_VC * DEPTH;
  localparam int MEM_AW  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [MEM_AW-1:0]     maddr_t;
  // One bit wider than the VC select so the range check is never a
  // constant comparison when NUM_VC is a power of two.
  typedef logic [VC_BITS:0]      vcx_t;

  // Storage and per-VC control state
  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  ptr_t                  rd_ptr_q [NUM_VC];
  ptr_t                  rd_ptr_d [NUM_VC];
  ptr_t                  wr_ptr_q [NUM_VC];
  ptr_t                  wr_ptr_d [NUM_VC];
  cnt_t                  count_q  [NUM_VC];
  cnt_t                  count_d  [NUM_VC];

  // Registered read path and error pulses
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // Request qualification
  logic   wvc_ok, rvc_ok;
  logic   rd_acc, wr_acc;
  logic   wr_vc_full;
  maddr_t waddr, raddr;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign wvc_ok = vcx_t'(buf_wvc_i) < vcx_t'(NUM_VC);
  assign rvc_ok = vcx_t'(buf_rvc_i) < vcx_t'(NUM_VC);

  // Read decision uses pre-edge occupancy only, so a same-cycle write
  // can never make an empty VC readable.
  assign rd_acc = buf_read_i && rvc_ok && (count_q[buf_rvc_i] != '0);

  assign wr_vc_full = (count_q[buf_wvc_i] == cnt_t'(DEPTH));

  // A full VC still accepts a write when the same VC is popped this cycle:
  // the write lands in the slot the read is vacating.
  assign wr_acc = buf_write_i && wvc_ok &&
                  (!wr_vc_full || (rd_acc && (buf_rvc_i == buf_wvc_i)));

  assign waddr = maddr_t'(int'(buf_wvc_i) * DEPTH + int'(wr_ptr_q[buf_wvc_i]));
  assign raddr = maddr_t'(int'(buf_rvc_i) * DEPTH + int'(rd_ptr_q[buf_rvc_i]));

  // NOTE: storage carries no reset; flits are invalidated by clearing the
  // pointers and counts, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[waddr] <= buf_data_i;
    end
  end

  // Next-state logic for pointers, counts and the output registers.
  always_comb begin
    // NOTE: every signal gets a default before any conditional update so
    // no path leaves it unassigned and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = rd_acc;
    ovf_d    = buf_write_i && !wr_acc;
    unf_d    = buf_read_i && !rd_acc;

    if (rd_acc) begin
      data_d = mem_q[raddr];
    end

    for (int v = 0; v < NUM_VC; v++) begin
      logic inc, dec;
      inc = wr_acc && (buf_wvc_i == VC_BITS'(v));
      dec = rd_acc && (buf_rvc_i == VC_BITS'(v));
      if (inc) wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
      if (dec) rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
      unique case ({inc, dec})
        2'b10:   count_d[v] = count_q[v] + cnt_t'(1);
        2'b01:   count_d[v] = count_q[v] - cnt_t'(1);
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Status is decoded from the count registers only: no path from requests.
  always_comb begin
    buf_empty_o = '0;
    buf_full_o  = '0;
    buf_count_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      buf_empty_o[v]                         = (count_q[v] == '0);
      buf_full_o[v]                          = (count_q[v] == cnt_t'(DEPTH));
      buf_count_o[v*CNT_WIDTH +: CNT_WIDTH]  = count_q[v];
    end
  end

  assign buf_data_o      = data_q;
  assign buf_valid_o     = valid_q;
  assign buf_overflow_o  = ovf_q;
  assign buf_underflow_o = unf_q;

endmodule

// File: tb/tb_input_buffer_vc.sv
// -----------------------------------------------------------------------------
// tb_input_buffer_vc
//
// Directed bench for input_buffer_vc with default parameters
// (DATA_WIDTH=16, DEPTH=5, NUM_VC=2, CNT_WIDTH=3). Inputs change 1 ns after
// the rising edge and outputs are sampled at the same point, away from the
// edge. Expected values are hand-derived constants, plus per-VC queues for
// the interleaved traffic phase.
// -----------------------------------------------------------------------------
module tb_input_buffer_vc;

  localparam int DW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          buf_write_i;
  logic          buf_wvc_i;
  logic [DW-1:0] buf_data_i;
  logic          buf_read_i;
  logic          buf_rvc_i;
  logic [DW-1:0] buf_data_o;
  logic          buf_valid_o;
  logic [1:0]    buf_empty_o;
  logic [1:0]    buf_full_o;
  logic [2*CW-1:0] buf_count_o;
  logic          buf_overflow_o;
  logic          buf_underflow_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  input_buffer_vc dut (
    .clk             (clk),
    .reset           (reset),
    .buf_write_i     (buf_write_i),
    .buf_wvc_i       (buf_wvc_i),
    .buf_data_i      (buf_data_i),
    .buf_read_i      (buf_read_i),
    .buf_rvc_i       (buf_rvc_i),
    .buf_data_o      (buf_data_o),
    .buf_valid_o     (buf_valid_o),
    .buf_empty_o     (buf_empty_o),
    .buf_full_o      (buf_full_o),
    .buf_count_o     (buf_count_o),
    .buf_overflow_o  (buf_overflow_o),
    .buf_underflow_o (buf_underflow_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of requests, clock it, and settle 1 ns past the edge.
  task automatic cyc(input logic w, input logic wvc, input logic [DW-1:0] wd,
                     input logic r, input logic rvc);
    buf_write_i = w;
    buf_wvc_i   = wvc;
    buf_data_i  = wd;
    buf_read_i  = r;
    buf_rvc_i   = rvc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt(input int v);
    return buf_count_o[v*CW +: CW];
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(buf_empty_o),     32'h3);
    check({tag, "_full"},  32'(buf_full_o),      32'h0);
    check({tag, "_count"}, 32'(buf_count_o),     32'h0);
    check({tag, "_valid"}, 32'(buf_valid_o),     32'h0);
    check({tag, "_data"},  32'(buf_data_o),      32'h0);
    check({tag, "_ovf"},   32'(buf_overflow_o),  32'h0);
    check({tag, "_unf"},   32'(buf_underflow_o), 32'h0);
  endtask

  initial begin
    reset       = 1'b1;
    buf_write_i = 1'b0;
    buf_wvc_i   = 1'b0;
    buf_data_i  = '0;
    buf_read_i  = 1'b0;
    buf_rvc_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_reset_state("idle");

    // Fill VC0 with 1..5, then drain in order.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
      check("fill0_count", 32'(cnt(0)), 32'(i));
      if (i == 4) check("fill0_full4", 32'(buf_full_o), 32'h0);
    end
    check("fill0_full",  32'(buf_full_o),  32'h1);
    check("fill0_empty", 32'(buf_empty_o), 32'h2);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      check("drain0_valid", 32'(buf_valid_o), 32'h1);
      check("drain0_data",  32'(buf_data_o),  32'(i));
    end
    check("drain0_empty", 32'(buf_empty_o), 32'h3);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("idle_valid", 32'(buf_valid_o), 32'h0);
    check("idle_hold",  32'(buf_data_o),  32'h5);

    // Fill VC1, then overflow with 0xBEEF.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("ovf_pulse",  32'(buf_overflow_o), 32'h1);
    check("ovf_count1", 32'(cnt(1)),         32'h5);
    check("ovf_full",   32'(buf_full_o),     32'h2);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("ovf_clear",  32'(buf_overflow_o), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      check("drain1_data", 32'(buf_data_o), 32'(16'h10 + i));
    end
    check("drain1_count", 32'(cnt(1)),      32'h0);
    check("drain1_empty", 32'(buf_empty_o), 32'h3);

    // Full VC0: simultaneous read and write both accepted.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 16'(16'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h00AA, 1'b1, 1'b0);
    check("rw_valid", 32'(buf_valid_o),    32'h1);
    check("rw_data",  32'(buf_data_o),     32'h21);
    check("rw_count", 32'(cnt(0)),         32'h5);
    check("rw_full",  32'(buf_full_o),     32'h1);
    check("rw_ovf",   32'(buf_overflow_o), 32'h0);
    for (int i = 2; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      check("rw_drain", 32'(buf_data_o), (i == 6) ? 32'hAA : 32'(16'h20 + i));
    end
    check("rw_empty", 32'(buf_empty_o), 32'h3);

    // Read empty VC0 while writing it: no bypass.
    cyc(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
    check("unf_pulse", 32'(buf_underflow_o), 32'h1);
    check("unf_valid", 32'(buf_valid_o),     32'h0);
    check("unf_hold",  32'(buf_data_o),      32'hAA);
    check("unf_count", 32'(cnt(0)),          32'h1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("unf_next_data",  32'(buf_data_o),      32'h1234);
    check("unf_next_valid", 32'(buf_valid_o),     32'h1);
    check("unf_next_clear", 32'(buf_underflow_o), 32'h0);

    // Interleave 15 flits per VC with alternating reads; pointers wrap.
    for (int i = 0; i < 30; i++) begin
      logic          vc, rv, r;
      logic [DW-1:0] wd, exp_d;
      vc    = 1'(i % 2);
      rv    = ~vc;
      wd    = 16'(16'hA000 + (int'(vc) * 16'h1000) + i);
      r     = rv ? (q1.size() != 0) : (q0.size() != 0);
      exp_d = '0;
      if (r) exp_d = rv ? q1.pop_front() : q0.pop_front();
      if (vc) q1.push_back(wd); else q0.push_back(wd);
      cyc(1'b1, vc, wd, r, rv);
      check("mix_valid", 32'(buf_valid_o), 32'(r));
      if (r) check("mix_data", 32'(buf_data_o), 32'(exp_d));
      check("mix_count0", 32'(cnt(0)), 32'(q0.size()));
      check("mix_count1", 32'(cnt(1)), 32'(q1.size()));
    end
    for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++) begin
      logic          rv;
      logic [DW-1:0] exp_d;
      rv    = (q0.size() == 0);
      exp_d = rv ? q1.pop_front() : q0.pop_front();
      cyc(1'b0, 1'b0, 16'h0, 1'b1, rv);
      check("mix_tail", 32'(buf_data_o), 32'(exp_d));
    end
    check("mix_end_empty", 32'(buf_empty_o), 32'h3);

    // Reset mid-traffic dominates requests and discards buffered flits.
    cyc(1'b1, 1'b0, 16'h0C01, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h0C02, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 16'h0C03, 1'b1, 1'b1);
    check_reset_state("midrst");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("postrst_unf",   32'(buf_underflow_o), 32'h1);
    check("postrst_valid", 32'(buf_valid_o),     32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
